// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // alu_op as consumed by alu_dec
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format select, decoded from the opcode independently of controller state.
module imm_src_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RISC-V main controller: Moore FSM sequencing fetch, decode, memory, ALU and branch steps.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic       illegal_op,
  output logic [3:0] busy_state
);

  state_t     state_reg;
  state_t     state_next;
  logic       pc_update;
  logic       branch;
  logic       adr_src_int;
  logic       mem_write_int;
  logic       ir_write_int;
  logic       reg_write_int;
  logic       illegal_int;
  logic [1:0] result_src_int;
  logic [1:0] alu_src_a_int;
  logic [1:0] alu_src_b_int;
  logic [1:0] alu_op_int;
  logic [1:0] imm_src_int;

  imm_src_dec u_imm_src_dec (
    .op      (op),
    .imm_src (imm_src_int)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RESET_STATE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = S_FETCH;
    pc_update      = 1'b0;
    branch         = 1'b0;
    adr_src_int    = 1'b0;
    mem_write_int  = 1'b0;
    ir_write_int   = 1'b0;
    reg_write_int  = 1'b0;
    illegal_int    = 1'b0;
    result_src_int = RES_ALUOUT;
    alu_src_a_int  = SRCA_PC;
    alu_src_b_int  = SRCB_RS2;
    alu_op_int     = ALU_OP_ADD;

    case (state_reg)
      S_FETCH: begin
        alu_src_b_int  = SRCB_FOUR;
        result_src_int = RES_ALURESULT;
        ir_write_int   = mem_ready;
        pc_update      = mem_ready;
        state_next     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // OldPC + imm is precomputed here so a taken branch/jump has its target ready
        alu_src_a_int = SRCA_OLDPC;
        alu_src_b_int = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            illegal_int = 1'b1;
            state_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_int = SRCA_RS1;
        alu_src_b_int = SRCB_IMM;
        if (op == OP_LW) begin
          state_next = S_MEMREAD;
        end else if (op == OP_SW) begin
          state_next = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        adr_src_int = 1'b1;
        state_next  = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWRITE: begin
        adr_src_int   = 1'b1;
        mem_write_int = mem_ready;
        state_next    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_MEMWB: begin
        result_src_int = RES_DATA;
        reg_write_int  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_int = SRCA_RS1;
        alu_op_int    = ALU_OP_FUNCT;
        state_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_int = SRCA_RS1;
        alu_src_b_int = SRCB_IMM;
        alu_op_int    = ALU_OP_FUNCT;
        state_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_int = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_int = SRCA_RS1;
        alu_op_int    = ALU_OP_SUB;
        branch        = 1'b1;
      end
      S_JAL: begin
        alu_src_a_int = SRCA_OLDPC;
        alu_src_b_int = SRCB_FOUR;
        pc_update     = 1'b1;
        state_next    = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Every output is held low for the whole reset window, not just after the first edge
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    illegal_op = 1'b0;
    if (rst_n) begin
      pc_write   = pc_update | (branch & zero);
      adr_src    = adr_src_int;
      mem_write  = mem_write_int;
      ir_write   = ir_write_int;
      result_src = result_src_int;
      alu_src_a  = alu_src_a_int;
      alu_src_b  = alu_src_b_int;
      alu_op     = alu_op_int;
      reg_write  = reg_write_int;
      imm_src    = imm_src_int;
      illegal_op = illegal_int;
    end
  end

  assign busy_state = state_reg;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized instruction-level bench for mc_ctrl_fsm against a per-instruction trace model.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0] busy_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.RESET_STATE(S_FETCH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .imm_src    (imm_src),
    .illegal_op (illegal_op),
    .busy_state (busy_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, illegal_op}
  function automatic logic [17:0] observed();
    return {busy_state, pc_write, adr_src, mem_write, ir_write, result_src,
            alu_src_a, alu_src_b, alu_op, reg_write, illegal_op};
  endfunction

  function automatic logic supported(input logic [6:0] o);
    return o inside {OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL};
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected control word for one cycle spent in step s, straight from the per-step output list
  function automatic logic [17:0] model(input state_t s, input logic mr, input logic z, input logic ill);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, ao;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00;
    case (s)
      S_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      S_MEMREAD:  begin adr = 1; end
      S_MEMWRITE: begin adr = 1; mw = mr; end
      S_MEMWB:    begin rs = 2'b01; rw = 1; end
      S_EXECR:    begin sa = 2'b10; ao = 2'b10; end
      S_EXECI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      S_ALUWB:    begin rw = 1; end
      S_BEQ:      begin sa = 2'b10; ao = 2'b01; pcw = z; end
      S_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default:    ;
    endcase
    return {4'(s), pcw, adr, mw, irw, rs, sa, sb, ao, rw, ill};
  endfunction

  // One clock cycle expected to be spent in step s with the given op and mem_ready
  task automatic step(input state_t s, input logic [6:0] o, input logic mr, input string tag);
    @(posedge clk);
    #1;
    op        = o;
    mem_ready = mr;
    zero      = 1'($urandom_range(0, 1));
    @(negedge clk);
    check({tag, "/ctl"}, 32'(observed()), 32'(model(s, mr, zero, (s == S_DECODE) && !supported(o))));
    check({tag, "/imm"}, 32'(imm_src), 32'(ref_imm(o)));
    check({tag, "/excl"}, 32'(int'(mem_write) + int'(ir_write) + int'(reg_write) <= 1), 32'd1);
  endtask

  task automatic run_instr(input int idx);
    logic [6:0] ops [6];
    logic [6:0] o;
    state_t     sq[$];
    logic       mq[$];
    int         k;
    int         fw;
    int         mwt;
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL};
    k   = $urandom_range(0, 6);
    if (k < 6) begin
      o = ops[k];
    end else if ($urandom_range(0, 1) == 1) begin
      o = 7'h7F;
    end else begin
      do o = 7'($urandom); while (supported(o));
    end
    fw  = $urandom_range(0, 2);
    mwt = $urandom_range(0, 3);
    // Instruction trace as a list of (step, mem_ready) pairs
    for (int i = 0; i < fw; i++) begin sq.push_back(S_FETCH); mq.push_back(1'b0); end
    sq.push_back(S_FETCH);  mq.push_back(1'b1);
    sq.push_back(S_DECODE); mq.push_back(1'($urandom_range(0, 1)));
    if (o == OP_LW || o == OP_SW) begin
      state_t ms;
      ms = (o == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      sq.push_back(S_MEMADR); mq.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < mwt; i++) begin sq.push_back(ms); mq.push_back(1'b0); end
      sq.push_back(ms); mq.push_back(1'b1);
      if (o == OP_LW) begin sq.push_back(S_MEMWB); mq.push_back(1'($urandom_range(0, 1))); end
    end else if (o == OP_RTYPE || o == OP_ITYPE || o == OP_JAL) begin
      sq.push_back(o == OP_RTYPE ? S_EXECR : (o == OP_ITYPE ? S_EXECI : S_JAL));
      mq.push_back(1'($urandom_range(0, 1)));
      sq.push_back(S_ALUWB); mq.push_back(1'($urandom_range(0, 1)));
    end else if (o == OP_BEQ) begin
      sq.push_back(S_BEQ); mq.push_back(1'($urandom_range(0, 1)));
    end
    $display("txn %0d op=%07b fetch_wait=%0d mem_wait=%0d cycles=%0d", idx, o, fw, mwt, sq.size());
    foreach (sq[i]) begin
      // op is only meaningful in DECODE/MEMADR; elsewhere it is scrambled
      step(sq[i], (sq[i] == S_DECODE || sq[i] == S_MEMADR) ? o : 7'($urandom),
           mq[i], $sformatf("t%0d.c%0d", idx, i));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    op        = OP_LW;
    zero      = 1'b1;
    mem_ready = 1'b1;
    #12;
    check("rst/ctl", 32'(observed()), 32'd0);
    check("rst/imm", 32'(imm_src), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;

    for (int n = 0; n < 80; n++) run_instr(n);

    // Reset pulled in the middle of a completing store
    step(S_FETCH,  7'($urandom), 1'b1, "ra/fetch");
    step(S_DECODE, OP_SW,        1'b1, "ra/decode");
    step(S_MEMADR, OP_SW,        1'b1, "ra/memadr");
    step(S_MEMWRITE, 7'($urandom), 1'b0, "ra/wait");
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    #1;
    check("ra/mw_pre", 32'(mem_write), 32'd1);
    check("ra/st_pre", 32'(busy_state), 32'(S_MEMWRITE));
    rst_n = 1'b0;
    #1;
    check("ra/mw_rst", 32'(mem_write), 32'd0);
    check("ra/ctl_rst", 32'(observed()), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;
    step(S_FETCH,  7'($urandom), 1'b1, "ra/refetch");
    step(S_DECODE, 7'h7F,        1'b1, "ra/decode2");
    step(S_FETCH,  7'($urandom), 1'b0, "ra/idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 The block SHALL have the parameter RESET_STATE, default S_FETCH, which is the state entered on reset.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- op, input, 7: instruction opcode field, taken from the instruction register.
- zero, input, 1: ALU zero flag.
- mem_ready, input, 1: the memory access completes this cycle.
- pc_write, output, 1: PC register load enable.
- adr_src, output, 1: memory address select; 0 = PC, 1 = ALU result.
- mem_write, output, 1: data memory write strobe.
- ir_write, output, 1: instruction register load enable.
- result_src, output, 2: result mux select.
- alu_src_a, output, 2: ALU A-operand select; 00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b, output, 2: ALU B-operand select; 00 = rs2, 01 = imm, 10 = constant 4.
- alu_op, output, 2: feeds alu_dec; 00 = add, 01 = sub, 10 = decode funct.
- reg_write, output, 1: register file write enable.
- imm_src, output, 2: immediate format select.
- illegal_op, output, 1: one-cycle pulse on an unsupported opcode.
- busy_state, output, 4: current state encoding, for debug.

Function
REQ-003 The block SHALL be a Moore FSM with 11 states: S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL.
REQ-004 Transitions SHALL be as follows; every transition not listed returns to S_FETCH:
- S_FETCH -> S_DECODE when mem_ready=1; otherwise hold.
- S_DECODE -> S_MEMADR for lw (0000011) and sw (0100011).
- S_DECODE -> S_EXECR for R-type (0110011).
- S_DECODE -> S_EXECI for I-type ALU (0010011).
- S_DECODE -> S_BEQ for beq (1100011).
- S_DECODE -> S_JAL for jal (1101111).
- S_DECODE -> S_FETCH for any other opcode.
- S_MEMADR -> S_MEMREAD when op=lw; -> S_MEMWRITE when op=sw.
- S_MEMREAD -> S_MEMWB when mem_ready=1; otherwise hold.
- S_MEMWRITE -> S_FETCH when mem_ready=1; otherwise hold.
- S_EXECR and S_EXECI -> S_ALUWB.
- S_JAL -> S_ALUWB.
- S_MEMWB, S_ALUWB and S_BEQ -> S_FETCH.
REQ-005 Per-state outputs SHALL be as follows; any signal not listed is 0:
- S_FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=mem_ready, pc_update=mem_ready.
- S_DECODE: alu_src_a=01, alu_src_b=01, alu_op=00.
- S_MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
- S_MEMREAD: adr_src=1, result_src=00.
- S_MEMWRITE: adr_src=1, mem_write=mem_ready.
- S_MEMWB: result_src=01, reg_write=1.
- S_EXECR: alu_src_a=10, alu_src_b=00, alu_op=10.
- S_EXECI: alu_src_a=10, alu_src_b=01, alu_op=10.
- S_ALUWB: result_src=00, reg_write=1.
- S_BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1.
- S_JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
REQ-006 pc_write SHALL equal pc_update OR (branch AND zero); this is the only combinational use of zero.
REQ-007 imm_src SHALL be decoded combinationally from op in every state:
- 00 for lw and I-type.
- 01 for sw.
- 10 for beq.
- 11 for jal.
- 00 for any other opcode.
REQ-008 illegal_op SHALL be 1 for exactly the S_DECODE cycle in which op is unsupported, and 0 otherwise.
REQ-009 Instruction latency with mem_ready held at 1 SHALL be:
- lw: 5 cycles.
- sw, R-type, I-type, jal: 4 cycles.
- beq: 3 cycles.
REQ-010 Each cycle mem_ready=0 in a wait state (S_FETCH, S_MEMREAD, S_MEMWRITE) SHALL add exactly one cycle, with no strobe asserted.
REQ-011 mem_write, ir_write and reg_write SHALL never be asserted in the same cycle as each other.
REQ-012 A change of op outside S_DECODE and S_MEMADR SHALL NOT affect the state sequence.

Reset
REQ-013 While rst_n=0 the state SHALL asynchronously become RESET_STATE, and all strobe outputs SHALL be forced to 0: pc_write, ir_write, mem_write, reg_write, illegal_op.
REQ-014 While rst_n=0 all select outputs SHALL be 0.
REQ-015 Reset asserted in any state SHALL abandon the instruction; after deassertion, fetch restarts on the next rising edge with no pending write.

Structure
REQ-016 The state encodings (4-bit) and opcode constants SHALL reside in the shared package mc_ctrl_pkg, together with:
- the alu_op encodings used by alu_dec;
- the result_src, alu_src_a and alu_src_b encodings.
REQ-017 The imm_src decode SHALL be the sub-module imm_src_dec, which is purely combinational.
REQ-018 The state register SHALL be the only sequential element.

Verification
REQ-019 lw, mem_ready=1: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in cycle 5 with result_src=01.
REQ-020 R-type (op=0110011): alu_op=10 in the EXECR cycle; reg_write=1 in cycle 4; pc_write=1 only in cycle 1.
REQ-021 beq: with zero=1, pc_write=1 in cycle 3; with zero=0, pc_write=0; return to FETCH in both cases.
REQ-022 sw with mem_ready=0 for 3 cycles in MEMWRITE: state holds with mem_write=0; mem_write=1 only in the cycle mem_ready=1.
REQ-023 op=1111111: illegal_op=1 for one cycle in DECODE, then FETCH; no write strobe asserted.
REQ-024 rst_n pulled low mid-S_MEMWRITE with mem_ready=1: mem_write drops to 0 immediately; after release the state is S_FETCH.
